// File: rtl/metronome_pkg.sv
// Shared types and elaboration-time helpers for the metronome output chain.
package metronome_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    TONE = 1'b1
  } bell_state_e;

  // Clock cycles per half period of a square wave at freq_hz.
  function automatic int half_count(input int clk_hz, input int freq_hz);
    return clk_hz / (2 * freq_hz);
  endfunction

  // Bits needed for a counter that runs 0 .. n-1 (never narrower than 1).
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bell_driver_if.sv
// Beat-in / buzzer-out signal bundle between the metronome stage and bell_driver.
interface bell_driver_if;
  logic       beat;
  logic       accent;
  logic       mute;
  logic [1:0] vol;
  logic       buzz;
  logic       busy;
  logic       beat_led;

  modport master (
    output beat, accent, mute, vol,
    input  buzz, busy, beat_led
  );

  modport slave (
    input  beat, accent, mute, vol,
    output buzz, busy, beat_led
  );
endinterface

// File: rtl/bell_driver_tone_osc.sv
// tone_osc: square-wave generator with selectable half period.
// restart forces a fresh high phase, stop parks the output low, run advances it.
module tone_osc
  import metronome_pkg::*;
#(
  parameter int HALF_N = 50,
  parameter int HALF_A = 25
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic stop,
  input  logic run,
  input  logic sel_accent,
  output logic phase_o,
  output logic phase_nxt_o
);

  localparam int HMAX = (HALF_N > HALF_A) ? HALF_N : HALF_A;
  localparam int HW   = cnt_width(HMAX);
  localparam logic [HW-1:0] HN_LAST = HW'(HALF_N - 1);
  localparam logic [HW-1:0] HA_LAST = HW'(HALF_A - 1);

  logic [HW-1:0] half_q, half_d;
  logic          phase_q, phase_d;
  logic [HW-1:0] half_last;

  // Next half-period count and phase; restart beats stop beats run.
  always_comb begin
    half_d    = half_q;
    phase_d   = phase_q;
    half_last = sel_accent ? HA_LAST : HN_LAST;
    if (restart) begin
      half_d  = '0;
      phase_d = 1'b1;
    end else if (stop) begin
      half_d  = '0;
      phase_d = 1'b0;
    end else if (run) begin
      if (half_q == half_last) begin
        half_d  = '0;
        phase_d = ~phase_q;
      end else begin
        half_d = half_q + 1'b1;
      end
    end
  end

  // Oscillator state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      half_q  <= half_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o     = phase_q;
  assign phase_nxt_o = phase_d;

endmodule

// File: rtl/bell_driver.sv
// bell_driver: turns metronome beat edges into fixed-length tone bursts.
// Optional VOLUME_PWM_EN adds a 4-step duty-cycle volume on the buzz output.
module bell_driver
  import metronome_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int TONE_HZ   = 1000,
  parameter int ACCENT_HZ = 2000,
  parameter int BEEP_MS   = 50
) (
  input  logic           clk,
  input  logic           rst_n,
  bell_driver_if.slave   bus
);

  localparam int HALF_N   = half_count(CLK_HZ, TONE_HZ);
  localparam int HALF_A   = half_count(CLK_HZ, ACCENT_HZ);
  localparam int BEEP_CYC = (CLK_HZ / 1000) * BEEP_MS;
  localparam int DW       = cnt_width(BEEP_CYC);
  localparam logic [DW-1:0] DUR_LAST = DW'(BEEP_CYC - 1);

  bell_state_e   state_q;
  logic          beat_q;   // beat delayed one cycle for edge detection
  logic          acc_q;
  logic          busy_q;
  logic [DW-1:0] dur_q;

  logic rise, start, last, stop;
  logic phase, phase_nxt;

  assign rise  = bus.beat & ~beat_q;
  // Mute wins over a rise; a rise wins over the end of a burst.
  assign start = rise & ~bus.mute;
  assign last  = (state_q == TONE) && (dur_q == DUR_LAST);
  assign stop  = bus.mute | last;

  // Burst FSM with duration counter, accent latch and busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= 1'b0;
      acc_q   <= 1'b0;
      busy_q  <= 1'b0;
      dur_q   <= '0;
    end else begin
      beat_q <= bus.beat;
      if (bus.mute) begin
        state_q <= IDLE;
        busy_q  <= 1'b0;
        dur_q   <= '0;
      end else if (rise) begin
        state_q <= TONE;
        busy_q  <= 1'b1;
        dur_q   <= '0;
        acc_q   <= bus.accent;
      end else if (state_q == TONE) begin
        if (last) begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          dur_q   <= '0;
        end else begin
          dur_q <= dur_q + 1'b1;
        end
      end
    end
  end

  tone_osc #(
    .HALF_N (HALF_N),
    .HALF_A (HALF_A)
  ) u_osc (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (start),
    .stop        (stop),
    .run         (state_q == TONE),
    .sel_accent  (acc_q),
    .phase_o     (phase),
    .phase_nxt_o (phase_nxt)
  );

`ifdef VOLUME_PWM_EN
  logic [1:0] pwm_q;
  logic [1:0] pwm_d;
  logic       buzz_q;
  logic       unused_phase;

  assign pwm_d        = pwm_q + 2'd1;
  assign unused_phase = phase;

  // Free-running PWM counter; buzz is gated against the values both take next cycle
  // so it stays a pure register output with the same latency as the ungated phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q  <= 2'd0;
      buzz_q <= 1'b0;
    end else begin
      pwm_q  <= pwm_d;
      buzz_q <= phase_nxt & (pwm_d <= bus.vol);
    end
  end

  assign bus.buzz = buzz_q;
`else
  logic unused_sig;
  assign unused_sig = ^{bus.vol, phase_nxt};
  assign bus.buzz   = phase;
`endif

  assign bus.busy     = busy_q;
  assign bus.beat_led = busy_q;

endmodule

// File: tb/tb_bell_driver.sv
// Directed testbench for bell_driver (scaled clock: HALF_N=50, HALF_A=25, BEEP_CYC=500).
module tb_bell_driver;

  localparam int BEEP = 500;
  localparam int HN   = 50;
  localparam int HA   = 25;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   errs, busy_n, errs2, busy_n2, cnt;

  bell_driver_if bus ();

  bell_driver #(
    .CLK_HZ    (100_000),
    .TONE_HZ   (1000),
    .ACCENT_HZ (2000),
    .BEEP_MS   (5)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Create a rising beat edge; on return the DUT sits at burst cycle 0.
  task automatic start_burst(input logic acc);
    bus.beat = 1'b0;
    tick();
    bus.accent = acc;
    bus.beat   = 1'b1;
    tick();
  endtask

  // Compare buzz/busy/beat_led per cycle against the ideal burst shape.
  // k0 is the burst cycle index of the first sample; rise_at (relative) drives a new edge.
  task automatic watch(input int n, input int k0, input int half, input int rise_at,
                       output int e, output int b);
    int  k;
    logic exp_on, exp_bz;
    e = 0;
    b = 0;
    for (int i = 0; i < n; i++) begin
      k      = k0 + i;
      exp_on = (k < BEEP);
      exp_bz = exp_on && (((k / half) % 2) == 0);
      if (bus.busy !== exp_on || bus.buzz !== exp_bz || bus.beat_led !== exp_on) e++;
      if (bus.busy === 1'b1) b++;
      bus.beat = (i == rise_at);
      tick();
    end
  endtask

  initial begin
    bus.beat   = 1'b0;
    bus.accent = 1'b0;
    bus.mute   = 1'b0;
    bus.vol    = 2'd3;
    #2;
    check("reset_buzz", bus.buzz, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_led", bus.beat_led, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_busy", bus.busy, 0);

    // Normal beat
    start_burst(1'b0);
    watch(520, 0, HN, -1, errs, busy_n);
    check("normal_pattern_errs", errs, 0);
    check("normal_busy_cycles", busy_n, BEEP);

    // Accented beat, accent drops mid-burst
    start_burst(1'b1);
    watch(100, 0, HA, -1, errs, busy_n);
    bus.accent = 1'b0;
    watch(420, 100, HA, -1, errs2, busy_n2);
    check("accent_pattern_errs", errs + errs2, 0);
    check("accent_busy_cycles", busy_n + busy_n2, BEEP);

    // Retrigger 300 cycles in: phase was low at cycle 299, restart must go high
    start_burst(1'b0);
    watch(300, 0, HN, 299, errs, busy_n);
    check("retrig_first_errs", errs, 0);
    check("retrig_restart_buzz", bus.buzz, 1);
    watch(520, 0, HN, -1, errs, busy_n);
    check("retrig_second_errs", errs, 0);
    check("retrig_busy_cycles", busy_n, BEEP);

    // Rise on the last cycle of a burst: retrigger wins
    start_burst(1'b0);
    watch(500, 0, HN, 499, errs, busy_n);
    check("endrise_first_errs", errs, 0);
    watch(520, 0, HN, -1, errs, busy_n);
    check("endrise_second_errs", errs, 0);
    check("endrise_busy_cycles", busy_n, BEEP);

    // Reset mid-burst
    start_burst(1'b0);
    watch(20, 0, HN, -1, errs, busy_n);
    rst_n = 1'b0;
    #1;
    check("rst_mid_buzz", bus.buzz, 0);
    check("rst_mid_busy", bus.busy, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    watch(20, BEEP, HN, -1, errs, busy_n);
    check("rst_after_quiet", errs, 0);

    // Mute at burst cycle 100
    start_burst(1'b0);
    watch(100, 0, HN, -1, errs, busy_n);
    check("mute_pre_errs", errs, 0);
    bus.mute = 1'b1;
    tick();
    check("mute_buzz", bus.buzz, 0);
    check("mute_busy", bus.busy, 0);
    bus.beat = 1'b1;
    repeat (3) tick();
    check("mute_rise_ignored", bus.busy, 0);
    bus.mute = 1'b0;
    repeat (5) tick();
    check("unmute_held_beat", bus.busy, 0);
    check("unmute_held_buzz", bus.buzz, 0);

    // Rise and mute on the same cycle: mute wins
    bus.beat = 1'b0;
    tick();
    bus.beat = 1'b1;
    bus.mute = 1'b1;
    tick();
    bus.mute = 1'b0;
    tick();
    check("rise_mute_same", bus.busy, 0);

    // After mute clears a fresh edge works again
    start_burst(1'b0);
    check("post_mute_busy", bus.busy, 1);
    check("post_mute_buzz", bus.buzz, 1);
    bus.mute = 1'b1;
    tick();
    bus.mute = 1'b0;

`ifdef VOLUME_PWM_EN
    // vol=0: one high cycle in four during the high phase
    bus.vol = 2'd0;
    start_burst(1'b0);
    cnt = 0;
    for (int i = 0; i < 48; i++) begin
      if (bus.buzz === 1'b1) cnt++;
      tick();
    end
    check("pwm_vol0_duty", cnt, 12);
    bus.mute = 1'b1;
    tick();
    bus.mute = 1'b0;
    bus.vol  = 2'd3;
    start_burst(1'b0);
    watch(520, 0, HN, -1, errs, busy_n);
    check("pwm_vol3_follows_phase", errs, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
